// File: rtl/prores_pkg.sv
// Shared definitions for the bitstream arbiter: FSM states, bit limit and
// the mapping from sequence phase to the requester that owns it.
package prores_pkg;

  // Largest beat the bit packer accepts in one cycle.
  localparam int unsigned MAX_BITS = 64;
  // Width needed to carry a clamped size (0..MAX_BITS).
  localparam int unsigned SizeOutW = $clog2(MAX_BITS + 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHdr   = 3'd1,
    StDc    = 3'd2,
    StAc    = 3'd3,
    StFlush = 3'd4,
    StDone  = 3'd5
  } arb_state_e;

  typedef enum logic [1:0] {
    ReqNone = 2'd0,
    ReqHdr  = 2'd1,
    ReqDc   = 2'd2,
    ReqAc   = 2'd3
  } req_e;

  // Requester granted in each state; non-data states grant nobody.
  function automatic req_e phase_owner(input arb_state_e st);
    req_e owner;
    case (st)
      StHdr:   owner = ReqHdr;
      StDc:    owner = ReqDc;
      StAc:    owner = ReqAc;
      default: owner = ReqNone;
    endcase
    return owner;
  endfunction

  // Ones in bit positions below size; size MAX_BITS keeps every bit.
  function automatic logic [MAX_BITS-1:0] size_mask(input logic [SizeOutW-1:0] size);
    logic [MAX_BITS-1:0] mask;
    if (32'(size) >= MAX_BITS) begin
      mask = '1;
    end else begin
      mask = (MAX_BITS'(1) << size) - MAX_BITS'(1);
    end
    return mask;
  endfunction

endpackage

// File: rtl/bitstream_arbiter_mux.sv
// Combinational grant path: picks the beat of the phase owner, clamps its
// size to MAX_BITS, masks the value and flags protocol violations.
module bitstream_arbiter_mux
  import prores_pkg::*;
#(
  parameter int unsigned SIZE_W = 7
) (
  input  arb_state_e            state,
  input  logic                  hdr_valid,
  input  logic                  hdr_last,
  input  logic [63:0]           hdr_val,
  input  logic [SIZE_W-1:0]     hdr_size,
  input  logic                  dc_valid,
  input  logic                  dc_last,
  input  logic [63:0]           dc_val,
  input  logic [SIZE_W-1:0]     dc_size,
  input  logic                  ac_valid,
  input  logic                  ac_last,
  input  logic [63:0]           ac_val,
  input  logic [SIZE_W-1:0]     ac_size,
  output logic                  grant_valid,
  output logic                  grant_last,
  output logic [63:0]           grant_val,
  output logic [SizeOutW-1:0]   grant_size,
  output logic                  oversize,
  output logic                  stray
);

  req_e              owner;
  logic [63:0]       sel_val;
  logic [SIZE_W-1:0] sel_size;
  logic [31:0]       size32;
  logic              over;

  // Select the owner's beat, clamp and mask it, and detect out-of-phase valids.
  always_comb begin
    owner       = phase_owner(state);
    grant_valid = 1'b0;
    grant_last  = 1'b0;
    sel_val     = '0;
    sel_size    = '0;
    case (owner)
      ReqHdr: begin
        grant_valid = hdr_valid;
        grant_last  = hdr_last;
        sel_val     = hdr_val;
        sel_size    = hdr_size;
      end
      ReqDc: begin
        grant_valid = dc_valid;
        grant_last  = dc_last;
        sel_val     = dc_val;
        sel_size    = dc_size;
      end
      ReqAc: begin
        grant_valid = ac_valid;
        grant_last  = ac_last;
        sel_val     = ac_val;
        sel_size    = ac_size;
      end
      default: ;
    endcase
    size32     = 32'(sel_size);
    over       = size32 > MAX_BITS;
    grant_size = over ? SizeOutW'(MAX_BITS) : size32[SizeOutW-1:0];
    grant_val  = sel_val & size_mask(grant_size);
    oversize   = grant_valid && over;
    stray      = (hdr_valid && (owner != ReqHdr)) ||
                 (dc_valid  && (owner != ReqDc))  ||
                 (ac_valid  && (owner != ReqAc));
  end

endmodule

// File: rtl/bitstream_arbiter.sv
// Sequences header, DC and AC requesters into a bit packer, then issues one
// flush beat and a completion pulse. Outputs to the packer are registered.
// Optional per-slice bit counter: define BITSTREAM_ARBITER_BITCOUNT_EN.
module bitstream_arbiter
  import prores_pkg::*;
#(
  parameter int unsigned SIZE_W = 7
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              slice_start,
  input  logic              hdr_valid,
  input  logic              hdr_last,
  input  logic [63:0]       hdr_val,
  input  logic [SIZE_W-1:0] hdr_size,
  input  logic              dc_valid,
  input  logic              dc_last,
  input  logic [63:0]       dc_val,
  input  logic [SIZE_W-1:0] dc_size,
  input  logic              ac_valid,
  input  logic              ac_last,
  input  logic [63:0]       ac_val,
  input  logic [SIZE_W-1:0] ac_size,
  output logic              hdr_ready,
  output logic              dc_ready,
  output logic              ac_ready,
  output logic              sb_enable,
  output logic              sb_flush_bit,
  output logic [63:0]       sb_val,
  output logic [63:0]       sb_size_of_bit,
  output logic              busy,
  output logic              slice_done,
  output logic              err,
  output logic [31:0]       slice_bit_count
);

  arb_state_e          state_q, state_d;
  logic                grant_valid, grant_last, oversize, stray;
  logic [63:0]         grant_val;
  logic [SizeOutW-1:0] grant_size;
  logic                start_acc, err_set;
  logic                sb_enable_q, sb_flush_q, err_q;
  logic [63:0]         sb_val_q;
  logic [SizeOutW-1:0] sb_size_q;

  bitstream_arbiter_mux #(
    .SIZE_W (SIZE_W)
  ) u_mux (
    .state       (state_q),
    .hdr_valid   (hdr_valid),
    .hdr_last    (hdr_last),
    .hdr_val     (hdr_val),
    .hdr_size    (hdr_size),
    .dc_valid    (dc_valid),
    .dc_last     (dc_last),
    .dc_val      (dc_val),
    .dc_size     (dc_size),
    .ac_valid    (ac_valid),
    .ac_last     (ac_last),
    .ac_val      (ac_val),
    .ac_size     (ac_size),
    .grant_valid (grant_valid),
    .grant_last  (grant_last),
    .grant_val   (grant_val),
    .grant_size  (grant_size),
    .oversize    (oversize),
    .stray       (stray)
  );

  assign start_acc = slice_start && (state_q == StIdle);
  assign err_set   = (slice_start && (state_q != StIdle)) || oversize || stray;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a granted beat with last moves to the following phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_acc) state_d = StHdr;
      StHdr:   if (grant_valid && grant_last) state_d = StDc;
      StDc:    if (grant_valid && grant_last) state_d = StAc;
      StAc:    if (grant_valid && grant_last) state_d = StFlush;
      StFlush: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs: readys follow the phase owner.
  always_comb begin
    hdr_ready  = phase_owner(state_q) == ReqHdr;
    dc_ready   = phase_owner(state_q) == ReqDc;
    ac_ready   = phase_owner(state_q) == ReqAc;
    busy       = state_q != StIdle;
    slice_done = state_q == StDone;
  end

  // Packer beat registers and sticky error; the flush beat is loaded from FLUSH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sb_enable_q <= 1'b0;
      sb_flush_q  <= 1'b0;
      sb_val_q    <= '0;
      sb_size_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      sb_enable_q <= (grant_valid && (grant_size != '0)) || (state_q == StFlush);
      sb_flush_q  <= state_q == StFlush;
      sb_val_q    <= grant_valid ? grant_val : '0;
      sb_size_q   <= grant_valid ? grant_size : '0;
      err_q       <= (start_acc ? 1'b0 : err_q) | err_set;
    end
  end

  assign sb_enable      = sb_enable_q;
  assign sb_flush_bit   = sb_flush_q;
  assign sb_val         = sb_val_q;
  assign sb_size_of_bit = 64'(sb_size_q);
  assign err            = err_q;

`ifdef BITSTREAM_ARBITER_BITCOUNT_EN
  logic [31:0] bit_count_q;
  logic [32:0] bit_sum;

  assign bit_sum = {1'b0, bit_count_q} + 33'(grant_size);

  // Saturating count of issued bits, restarted by each accepted slice_start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_count_q <= '0;
    end else if (start_acc) begin
      bit_count_q <= '0;
    end else if (grant_valid) begin
      bit_count_q <= bit_sum[32] ? '1 : bit_sum[31:0];
    end
  end

  assign slice_bit_count = bit_count_q;
`else
  assign slice_bit_count = '0;
`endif

endmodule

// File: tb/tb_bitstream_arbiter.sv
// Scoreboard bench for bitstream_arbiter: directed scenarios plus random slices.
module tb_bitstream_arbiter;

  localparam int SIZE_W = 7;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              slice_start;
  logic              hdr_valid, hdr_last, dc_valid, dc_last, ac_valid, ac_last;
  logic [63:0]       hdr_val, dc_val, ac_val;
  logic [SIZE_W-1:0] hdr_size, dc_size, ac_size;
  logic              hdr_ready, dc_ready, ac_ready;
  logic              sb_enable, sb_flush_bit, busy, slice_done, err;
  logic [63:0]       sb_val, sb_size_of_bit;
  logic [31:0]       slice_bit_count;

  bitstream_arbiter #(
    .SIZE_W (SIZE_W)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .slice_start     (slice_start),
    .hdr_valid       (hdr_valid),
    .hdr_last        (hdr_last),
    .hdr_val         (hdr_val),
    .hdr_size        (hdr_size),
    .dc_valid        (dc_valid),
    .dc_last         (dc_last),
    .dc_val          (dc_val),
    .dc_size         (dc_size),
    .ac_valid        (ac_valid),
    .ac_last         (ac_last),
    .ac_val          (ac_val),
    .ac_size         (ac_size),
    .hdr_ready       (hdr_ready),
    .dc_ready        (dc_ready),
    .ac_ready        (ac_ready),
    .sb_enable       (sb_enable),
    .sb_flush_bit    (sb_flush_bit),
    .sb_val          (sb_val),
    .sb_size_of_bit  (sb_size_of_bit),
    .busy            (busy),
    .slice_done      (slice_done),
    .err             (err),
    .slice_bit_count (slice_bit_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned cyc;
    logic [63:0] val;
    logic [63:0] size;
    logic        flush;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned done_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        exp_err = 1'b0;
  longint unsigned model_bits = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: bits at and above the issued size are dropped.
  function automatic logic [63:0] ref_mask(input logic [63:0] v, input int s);
    if (s >= 64) return v;
    return v & ((64'd1 << s) - 64'd1);
  endfunction

  function automatic logic rdy(input int w);
    case (w)
      0:       return hdr_ready;
      1:       return dc_ready;
      default: return ac_ready;
    endcase
  endfunction

  // Monitor: one sample per cycle, compared against the scoreboard queues.
  always @(posedge clock) begin
    exp_t e;
    cyc++;
    #1;
    if (sb_enable) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'(sb_enable), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("beat_cycle", 64'(cyc), 64'(e.cyc));
        check("beat_val", sb_val, e.val);
        check("beat_size", sb_size_of_bit, e.size);
        check("beat_flush", 64'(sb_flush_bit), 64'(e.flush));
      end
    end else begin
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        check("missing_beat", 64'(sb_enable), 64'd1);
        void'(exp_q.pop_front());
      end
      check("idle_zero", sb_val | sb_size_of_bit | 64'(sb_flush_bit), 64'd0);
    end
    if (slice_done) begin
      if (done_q.size() == 0) check("unexpected_done", 64'(slice_done), 64'd0);
      else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
    end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
      check("missing_done", 64'(slice_done), 64'd1);
      void'(done_q.pop_front());
    end
  end

  task automatic clear_inputs();
    hdr_valid = 0; hdr_last = 0; hdr_val = '0; hdr_size = '0;
    dc_valid  = 0; dc_last  = 0; dc_val  = '0; dc_size  = '0;
    ac_valid  = 0; ac_last  = 0; ac_val  = '0; ac_size  = '0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int w, input logic [63:0] v, input int s, input logic l);
    int n = 0;
    int cs;
    case (w)
      0: begin hdr_valid = 1; hdr_val = v; hdr_size = SIZE_W'(s); hdr_last = l; end
      1: begin dc_valid  = 1; dc_val  = v; dc_size  = SIZE_W'(s); dc_last  = l; end
      default: begin ac_valid = 1; ac_val = v; ac_size = SIZE_W'(s); ac_last = l; end
    endcase
    while (!rdy(w) && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) begin
      check("ready_timeout", 64'd0, 64'd1);
    end else begin
      cs = (s > 64) ? 64 : s;
      if (s > 64) exp_err = 1'b1;
      if (cs != 0) exp_q.push_back('{cyc + 1, ref_mask(v, cs), 64'(cs), 1'b0});
      model_bits = model_bits + longint'(cs);
      if (model_bits > 64'hFFFF_FFFF) model_bits = 64'hFFFF_FFFF;
      if (l && w == 2) begin
        exp_q.push_back('{cyc + 2, 64'd0, 64'd0, 1'b1});
        done_q.push_back(cyc + 2);
      end
    end
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic start_slice();
    slice_start = 1'b1;
    @(negedge clock);
    slice_start = 1'b0;
    exp_err    = 1'b0;
    model_bits = 0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_hdr_ready", 64'(hdr_ready), 64'd1);
    check("start_err_clear", 64'(err), 64'd0);
  endtask

  task automatic finish_slice();
    int n = 0;
    logic [31:0] exp_cnt;
    while (!slice_done && n < 10) begin
      @(negedge clock);
      n++;
    end
    if (n >= 10) check("done_timeout", 64'd0, 64'd1);
    @(negedge clock);
`ifdef BITSTREAM_ARBITER_BITCOUNT_EN
    exp_cnt = 32'(model_bits);
`else
    exp_cnt = 32'd0;
`endif
    check("end_busy", 64'(busy), 64'd0);
    check("end_err", 64'(err), 64'(exp_err));
    check("end_bit_count", 64'(slice_bit_count), 64'(exp_cnt));
  endtask

  initial begin
    reset_n = 1'b0;
    slice_start = 1'b0;
    clear_inputs();
    #1;
    check("rst_outputs", sb_val | sb_size_of_bit |
          64'({sb_enable, sb_flush_bit, busy, slice_done, err, hdr_ready, dc_ready, ac_ready}),
          64'd0);
    check("rst_bit_count", 64'(slice_bit_count), 64'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Basic slice, started on the first edge after reset release.
    start_slice();
    send(0, 64'hA5, 8, 1'b0);
    send(0, 64'h3, 2, 1'b1);
    send(1, 64'h1F, 5, 1'b1);
    send(2, 64'h6, 3, 1'b1);
    finish_slice();
`ifdef BITSTREAM_ARBITER_BITCOUNT_EN
    check("bit_count_18", 64'(slice_bit_count), 64'd18);
`endif

    // AC valid during the header phase is refused and flags an error.
    start_slice();
    ac_valid = 1; ac_val = 64'hFF; ac_size = 7'd4; ac_last = 1;
    repeat (2) begin
      @(negedge clock);
      check("stray_ac_ready", 64'(ac_ready), 64'd0);
    end
    clear_inputs();
    exp_err = 1'b1;
    check("stray_err", 64'(err), 64'd1);
    check("stray_still_hdr", 64'(hdr_ready), 64'd1);
    send(0, 64'h12, 5, 1'b1);
    send(1, 64'h2, 2, 1'b1);
    send(2, 64'h1, 1, 1'b1);
    finish_slice();

    // Oversized header beat and a zero-size DC last beat.
    start_slice();
    send(0, 64'hFFFF_FFFF_FFFF_FFFF, 100, 1'b1);
    check("oversize_err", 64'(err), 64'd1);
    send(1, 64'hDEAD, 0, 1'b1);
    check("zero_last_ac_ready", 64'(ac_ready), 64'd1);
    send(2, 64'h5, 3, 1'b1);
    finish_slice();

    // slice_start while busy is ignored but flagged.
    start_slice();
    send(0, 64'h7, 3, 1'b1);
    slice_start = 1'b1;
    @(negedge clock);
    slice_start = 1'b0;
    exp_err = 1'b1;
    check("busy_start_err", 64'(err), 64'd1);
    check("busy_start_dc_ready", 64'(dc_ready), 64'd1);
    send(1, 64'h9, 4, 1'b1);
    send(2, 64'h3, 2, 1'b1);
    finish_slice();

    // Asynchronous reset while a DC beat is on the packer outputs.
    start_slice();
    send(0, 64'h1, 1, 1'b1);
    send(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 90, 1'b0);
    check("pre_reset_enable", 64'(sb_enable), 64'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_outputs", sb_val | sb_size_of_bit |
          64'({sb_enable, sb_flush_bit, busy, slice_done, err, hdr_ready, dc_ready, ac_ready}),
          64'd0);
    check("async_rst_count", 64'(slice_bit_count), 64'd0);
    exp_q.delete();
    done_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    start_slice();
    send(0, 64'hA5, 8, 1'b0);
    send(0, 64'h3, 2, 1'b1);
    send(1, 64'h1F, 5, 1'b1);
    send(2, 64'h6, 3, 1'b1);
    finish_slice();

    // Random slices.
    for (int k = 0; k < 20; k++) begin
      start_slice();
      for (int w = 0; w < 3; w++) begin
        int nb = $urandom_range(1, 4);
        for (int b = 0; b < nb; b++) begin
          int s;
          logic [63:0] v;
          v = {$urandom(), $urandom()};
          s = ($urandom_range(0, 9) == 0) ? $urandom_range(65, 127) : $urandom_range(0, 64);
          repeat ($urandom_range(0, 2)) @(negedge clock);
          send(w, v, s, b == nb - 1);
        end
      end
      finish_slice();
    end

    repeat (3) @(negedge clock);
    check("queues_drained", 64'(exp_q.size() + done_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitstream_arbiter.md
BITSTREAM_ARBITER -- requirements
Module: bitstream_arbiter

Interface
REQ-001 Parameter SIZE_W, default 7: width of each requester's size_of_bit field; legal sizes are 0..64.
REQ-002 clock  input  1  single clock for all logic.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 slice_start  input  1  one-cycle pulse that starts a slice sequence.
REQ-005 hdr_valid/hdr_last  input  1/1  header requester beat valid / final beat of phase.
REQ-006 hdr_val, hdr_size  input  64/SIZE_W  header bits (LSB-aligned), bit count.
REQ-007 dc_valid/dc_last, dc_val, dc_size  input  1/1/64/SIZE_W  DC requester, same meaning as header.
REQ-008 ac_valid/ac_last, ac_val, ac_size  input  1/1/64/SIZE_W  AC requester, same meaning as header.
REQ-009 hdr_ready, dc_ready, ac_ready  output  1 each  beat accepted when valid&&ready.
REQ-010 sb_enable, sb_flush_bit  output  1/1  drive the bit packer's enable and flush_bit.
REQ-011 sb_val, sb_size_of_bit  output  64/64  packer value and size, with size zero-extended.
REQ-012 busy, slice_done, err  output  1/1/1  sequence active, one-cycle completion pulse, sticky protocol error.
REQ-013 slice_bit_count  output  32  total bits issued in the current slice.

Function
REQ-014 FSM states are IDLE, HDR, DC, AC, FLUSH, DONE, encoded in 3 bits.
REQ-015 IDLE->HDR on slice_start; slice_start in any other state is ignored and sets err.
REQ-016 Only the requester owning the current phase has ready=1 (HDR: hdr, DC: dc, AC: ac); all other readys are 0.
REQ-017 An accepted beat with size 1..64 appears on sb_enable=1/sb_val/sb_size_of_bit exactly 1 cycle later (registered outputs).
REQ-018 An accepted beat with size 0 produces no sb_enable but still honours last.
REQ-019 An accepted beat with size >64 is clamped to 64 and sets err.
REQ-020 sb_val bits at and above the issued size are forced to 0.
REQ-021 An accepted beat with last=1 advances the phase HDR->DC->AC->FLUSH on the next cycle; the same beat is still issued.
REQ-022 valid from a requester outside its phase is not accepted and sets err.
REQ-023 In FLUSH, one cycle asserts sb_enable=1 and sb_flush_bit=1 with sb_val=0 and size 0, then the FSM goes to DONE.
REQ-024 In DONE, slice_done=1 for one cycle, then the FSM goes to IDLE.
REQ-025 busy=1 in every state except IDLE.
REQ-026 err clears on the accepted slice_start from IDLE and otherwise holds until reset.
REQ-027 sb_* outputs are 0 on every cycle with no issued beat or flush.

Reset
REQ-028 Asserting reset_n low, including mid-slice, forces IDLE immediately: all outputs 0, err=0, slice_bit_count=0, and pending beats are discarded.
REQ-029 The first slice_start is honoured on the first clock edge after reset_n deasserts.

Configuration
REQ-030 Macro BITSTREAM_ARBITER_BITCOUNT_EN defined: slice_bit_count clears on slice start and adds each issued (clamped) size, saturating at 0xFFFFFFFF.
REQ-031 Macro BITSTREAM_ARBITER_BITCOUNT_EN undefined: slice_bit_count is tied to 0 and no counter logic is built.

Structure
REQ-032 The FSM state enum, the limit MAX_BITS=64, and the phase-to-requester mapping live in the shared package prores_pkg.
REQ-033 One sub-module, bitstream_arbiter_mux, performs the combinational select, clamp and mask of the granted beat; state and registers stay in the top.

Verification
REQ-034 Reset, slice_start, then hdr beats (0xA5,8) and (0x3,2,last), dc (0x1F,5,last), ac (0x6,3,last) -> sb beats in that order each 1 cycle after acceptance, then one flush cycle, slice_done, slice_bit_count=18 with the macro defined.
REQ-035 ac_valid=1 during the HDR phase -> ac_ready=0, no issue, err=1 until the next slice_start.
REQ-036 dc beat with size=0 and last=1 -> no sb_enable, phase moves to AC next cycle.
REQ-037 hdr beat with size=100 and val=all-ones -> sb_size_of_bit=64, sb_val=all-ones, err=1.
REQ-038 reset_n pulsed low during the DC phase -> outputs 0 asynchronously, busy=0; a new slice then completes normally.
REQ-039 slice_start while busy -> ignored, err=1, current sequence completes unchanged.
